shift_unit_iter: RTL and testbench

SHIFT_UNIT_ITER -- requirements
Module: shift_unit_iter

---
 rtl/shift_unit_iter.sv | 70 +++++++
 tb/tb_shift_unit_iter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shift_unit_iter.sv
// shift_unit_iter: multi-cycle shifter (SLL/SRL/SRA/ROR) that moves at most STEP bit positions per cycle.
module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic               busy_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               done_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10;
    localparam logic [SHAMT_W:0] STEP_L  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W+1)'(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] work, work_n, shifted;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic [1:0] op, op_n;
    logic [SHAMT_W:0] amt;
    logic accept;
    assign accept = start_i && (state == IDLE || state == DONE);
    // amt never exceeds cnt, so the narrowing below in cnt_n is lossless
    assign amt = ({1'b0, cnt} < STEP_L) ? {1'b0, cnt} : STEP_L;
    always_comb begin
        shifted = op == SLL ? work << amt :
                  op == SRL ? work >> amt :
                  op == SRA ? $unsigned($signed(work) >>> amt) :
                  (work >> amt) | (work << (WIDTH_L - amt));
    end
    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        op_n    = op;
        if (accept) begin
            work_n  = data_i;
            cnt_n   = shamt_i;
            op_n    = op_i;
            state_n = shamt_i == '0 ? DONE : SHIFT;
        end else if (state == SHIFT) begin
            work_n  = shifted;
            cnt_n   = cnt - amt[SHAMT_W-1:0];
            state_n = cnt_n == '0 ? DONE : SHIFT;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op    <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            cnt   <= cnt_n;
            op    <= op_n;
        end
    end
    assign busy_o = state == SHIFT;
    assign done_o = state == DONE;
    assign data_o = work;
endmodule

// File: tb/tb_shift_unit_iter.sv
// tb_shift_unit_iter: table-driven and sequence checks of shift_unit_iter at WIDTH=32, STEP=4.
module tb_shift_unit_iter;
    logic        clk = 0;
    logic        rst_i = 0;
    logic        start_i = 0;
    logic [31:0] data_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [1:0]  op_i = '0;
    logic        busy_o, done_o;
    logic [31:0] data_o;
    int n_cmp = 0, n_bad = 0;

    shift_unit_iter #(.WIDTH(32), .STEP(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .data_i(data_i),
        .shamt_i(shamt_i), .op_i(op_i), .busy_o(busy_o), .data_o(data_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op);
        start_i = s;
        data_i  = d;
        shamt_i = sh;
        op_i    = op;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] res;
        int          k;
    } vec_t;
    vec_t v[11];

    initial begin
        int done_at, busy_n;
        logic [31:0] res;
        v[0]  = '{32'h00000001, 5'd2,  2'b00, 32'h00000004, 1};
        v[1]  = '{32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 8};
        v[2]  = '{32'h80000000, 5'd31, 2'b01, 32'h00000001, 8};
        v[3]  = '{32'h12345678, 5'd8,  2'b11, 32'h78123456, 2};
        v[4]  = '{32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF, 0};
        v[5]  = '{32'h0000F00F, 5'd4,  2'b11, 32'hF0000F00, 1};
        v[6]  = '{32'h7FFFFFFF, 5'd5,  2'b10, 32'h03FFFFFF, 2};
        v[7]  = '{32'hA5A5A5A5, 5'd31, 2'b00, 32'h80000000, 8};
        v[8]  = '{32'h12345678, 5'd3,  2'b01, 32'h02468ACF, 1};
        v[9]  = '{32'h80000001, 5'd31, 2'b11, 32'h00000003, 8};
        v[10] = '{32'hF0000000, 5'd6,  2'b10, 32'hFFC00000, 2};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset data", data_o, 32'd0);
        rst_i = 1;
        @(negedge clk);
        check("idle busy", {31'd0, busy_o}, 32'd0);

        foreach (v[i]) begin
            @(negedge clk);
            drive(1, v[i].d, v[i].sh, v[i].op);
            @(negedge clk);
            start_i = 0;
            done_at = 0;
            busy_n  = 0;
            res     = '0;
            for (int c = 1; c <= 20 && (done_at == 0 || c <= done_at + 1); c++) begin
                if (c > 1) @(negedge clk);
                if (done_at != 0 && c == done_at + 1)
                    check($sformatf("vec%0d done width", i), {31'd0, done_o}, 32'd0);
                busy_n += int'(busy_o);
                if (done_o && done_at == 0) begin
                    done_at = c;
                    res = data_o;
                end
            end
            check($sformatf("vec%0d latency", i), done_at, v[i].k + 1);
            check($sformatf("vec%0d busy cycles", i), busy_n, v[i].k);
            check($sformatf("vec%0d result", i), res, v[i].res);
        end

        // start during SHIFT is ignored; start in the DONE cycle is accepted back-to-back
        @(negedge clk);
        drive(1, 32'h00000001, 5'd8, 2'b00);
        @(negedge clk);
        check("seqA busy N+1", {31'd0, busy_o}, 32'd1);
        drive(1, 32'hFFFFFFFF, 5'd4, 2'b01);
        @(negedge clk);
        start_i = 0;
        check("seqA busy N+2", {31'd0, busy_o}, 32'd1);
        check("seqA no early done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        check("seqA done N+3", {31'd0, done_o}, 32'd1);
        check("seqA result1", data_o, 32'h00000100);
        drive(1, 32'h00000010, 5'd4, 2'b01);
        @(negedge clk);
        start_i = 0;
        check("seqA gap done", {31'd0, done_o}, 32'd0);
        check("seqA op2 busy", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check("seqA done2", {31'd0, done_o}, 32'd1);
        check("seqA result2", data_o, 32'h00000001);
        @(negedge clk);
        check("seqA idle after", {31'd0, done_o | busy_o}, 32'd0);
        check("seqA hold result", data_o, 32'h00000001);

        // reset mid-operation aborts with no later done pulse
        drive(1, 32'h80000000, 5'd31, 2'b10);
        @(negedge clk);
        start_i = 0;
        @(negedge clk);
        check("seqB busy N+2", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        rst_i = 0;
        @(negedge clk);
        check("seqB rst busy", {31'd0, busy_o}, 32'd0);
        check("seqB rst done", {31'd0, done_o}, 32'd0);
        check("seqB rst data", data_o, 32'd0);
        rst_i = 1;
        busy_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            busy_n += int'(done_o) + int'(busy_o);
        end
        check("seqB no activity after abort", busy_n, 0);

        // reset wins over a simultaneous start
        drive(1, 32'h00000001, 5'd0, 2'b00);
        rst_i = 0;
        @(negedge clk);
        rst_i = 1;
        start_i = 0;
        check("seqC rst prio done", {31'd0, done_o}, 32'd0);
        check("seqC rst prio data", data_o, 32'd0);
        @(negedge clk);
        check("seqC still idle", {31'd0, done_o | busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
